// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the UART FIFO pointer/flag controller.
// The FIFO depth and almost-full defaults are used by the RX and TX FIFOs.
package fifo_ctrl_pkg;

  localparam int unsigned FifoW    = 3;
  localparam int unsigned AfMargin = 1;

  // Request encoding is {wr, rd}.
  typedef enum logic [1:0] {
    OpIdle = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake bundle between the FIFO wrapper (master) and fifo_ctrl (slave).
// Carries level/almost_full only when FIFO_LEVEL_EN is defined.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned W = FifoW
) ();

  logic         wr;
  logic         rd;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [W-1:0] r_addr;
  logic         full;
  logic         empty;
`ifdef FIFO_LEVEL_EN
  logic [W:0]   level;
  logic         almost_full;

  modport master (
    output wr, rd,
    input  wr_en, w_addr, r_addr, full, empty, level, almost_full
  );

  modport slave (
    input  wr, rd,
    output wr_en, w_addr, r_addr, full, empty, level, almost_full
  );
`else
  modport master (
    output wr, rd,
    input  wr_en, w_addr, r_addr, full, empty
  );

  modport slave (
    input  wr, rd,
    output wr_en, w_addr, r_addr, full, empty
  );
`endif

endinterface

// File: rtl/fifo_ctrl.sv
// Circular write/read pointer and full/empty flag controller for a 2**W entry FIFO.
// Define FIFO_LEVEL_EN to add the registered occupancy counter and almost_full flag.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned W = FifoW
`ifdef FIFO_LEVEL_EN
  ,
  parameter int unsigned AF_MARGIN = AfMargin
`endif
) (
  input logic       clk,
  input logic       rst,
  fifo_ctrl_if.slave bus
);

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic [W-1:0] w_inc, r_inc;
  fifo_op_e     op;

`ifdef FIFO_LEVEL_EN
  localparam logic [W:0] AfThresh = (W+1)'((1 << W) - AF_MARGIN);

  logic [W:0] level_q, level_d;
  logic       almost_full_q, almost_full_d;
`endif

  assign op    = fifo_op_e'({bus.wr, bus.rd});
  assign w_inc = w_ptr_q + 1'b1;
  assign r_inc = r_ptr_q + 1'b1;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    full_d  = full_q;
    empty_d = empty_q;
`ifdef FIFO_LEVEL_EN
    level_d = level_q;
`endif
    unique case (op)
      OpIdle: ;
      OpPop: begin
        if (!empty_q) begin
          r_ptr_d = r_inc;
          full_d  = 1'b0;
          empty_d = (r_inc == w_ptr_q);
`ifdef FIFO_LEVEL_EN
          level_d = level_q - 1'b1;
`endif
        end
      end
      OpPush: begin
        if (!full_q) begin
          w_ptr_d = w_inc;
          empty_d = 1'b0;
          full_d  = (w_inc == r_ptr_q);
`ifdef FIFO_LEVEL_EN
          level_d = level_q + 1'b1;
`endif
        end
      end
      OpBoth: begin
        // A pop on empty is never bypassed, so only the push is taken.
        w_ptr_d = w_inc;
        if (empty_q) begin
          empty_d = 1'b0;
`ifdef FIFO_LEVEL_EN
          level_d = level_q + 1'b1;
`endif
        end else begin
          r_ptr_d = r_inc;
        end
      end
      default: ;
    endcase
`ifdef FIFO_LEVEL_EN
    almost_full_d = (level_d >= AfThresh);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
`ifdef FIFO_LEVEL_EN
      level_q       <= '0;
      almost_full_q <= 1'b0;
`endif
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
`ifdef FIFO_LEVEL_EN
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
`endif
    end
  end

  // When full, a simultaneous pop frees the slot being written.
  assign bus.wr_en  = bus.wr & (~full_q | bus.rd);
  assign bus.w_addr = w_ptr_q;
  assign bus.r_addr = r_ptr_q;
  assign bus.full   = full_q;
  assign bus.empty  = empty_q;
`ifdef FIFO_LEVEL_EN
  assign bus.level       = level_q;
  assign bus.almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural register file and a data scoreboard.
// Honours FIFO_LEVEL_EN for the level/almost_full checks.
module tb_fifo_ctrl;

  localparam int unsigned W     = 3;
  localparam int unsigned Depth = 1 << W;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [7:0] mem [Depth];
  logic [7:0] r_data;

  int checks = 0;
  int errors = 0;

  // Bench model: occupancy and pointers, plus expected pop data.
  int         cnt = 0;
  int         wp  = 0;
  int         rp  = 0;
  logic [7:0] exp_q [$];

  fifo_ctrl_if #(.W(W)) bus ();

  fifo_ctrl #(
    .W(W)
`ifdef FIFO_LEVEL_EN
    ,
    .AF_MARGIN(1)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.w_addr] <= din;
  end
  assign r_data = mem[bus.r_addr];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(cnt == Depth));
    chk({tag, ".w_addr"}, 32'(bus.w_addr), 32'(wp));
    chk({tag, ".r_addr"}, 32'(bus.r_addr), 32'(rp));
`ifdef FIFO_LEVEL_EN
    chk({tag, ".level"}, 32'(bus.level), 32'(cnt));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(cnt >= Depth - 1));
`endif
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d);
    bit pop_ok;
    bit push_ok;
    pop_ok  = r && (cnt > 0);
    push_ok = w && ((cnt < Depth) || r);
    bus.wr = w;
    bus.rd = r;
    din    = d;
    #2;
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(push_ok));
    if (pop_ok) chk({tag, ".r_data"}, 32'(r_data), 32'(exp_q[0]));
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    if (pop_ok) begin
      void'(exp_q.pop_front());
      rp = (rp + 1) % Depth;
      cnt--;
    end
    if (push_ok) begin
      exp_q.push_back(d);
      wp = (wp + 1) % Depth;
      cnt++;
    end
    check_state(tag);
  endtask

  task automatic do_reset(input logic w, input logic [7:0] d);
    rst    = 1'b0;
    bus.wr = w;
    bus.rd = 1'b0;
    din    = d;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    bus.wr = 1'b0;
    cnt    = 0;
    wp     = 0;
    rp     = 0;
    exp_q.delete();
  endtask

  initial begin
    rst    = 1'b0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    din    = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 8'h00);

    // Reset then idle.
    step("idle", 1'b0, 1'b0, 8'h00);

    // Fill from empty, reject a ninth push, drain in order, pop on empty.
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 8'(8'h10 + i));
    step("push_full", 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 8'h00);
    step("pop_empty", 1'b0, 1'b1, 8'h00);

    // Simultaneous push/pop on empty, then on full.
    do_reset(1'b0, 8'h00);
    step("both_empty", 1'b1, 1'b1, 8'h20);
    for (int i = 1; i < 8; i++) step("fill2", 1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) step("both_full", 1'b1, 1'b1, 8'(8'h30 + i));
    step("both_mid_pre", 1'b0, 1'b1, 8'h00);
    step("both_mid", 1'b1, 1'b1, 8'h40);
    while (cnt > 0) step("drain2", 1'b0, 1'b1, 8'h00);

    // Push 5, pop 3, push 6 wraps the write pointer back to 3.
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step("wrap_push", 1'b1, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 3; i++) step("wrap_pop", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) step("wrap_push2", 1'b1, 1'b0, 8'(8'h60 + i));
    chk("wrap.w_addr3", 32'(bus.w_addr), 32'd3);
    chk("wrap.r_addr3", 32'(bus.r_addr), 32'd3);
    chk("wrap.full", 32'(bus.full), 32'd1);
    while (cnt > 0) step("wrap_drain", 1'b0, 1'b1, 8'h00);

    // Reset with four entries held and a push during the reset cycle.
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'h70 + i));
    do_reset(1'b1, 8'hEE);
    check_state("mid_rst");
    step("post_rst_push", 1'b1, 1'b0, 8'h55);
    step("post_rst_pop", 1'b0, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
